// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the multi-requester APB master.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_REGION_BYTES    = 32'h1000;
  localparam logic [31:0] APB_DECODE_ERR_DATA = 32'hBAD1_BAD1;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Requester arbiter. Build option APB_ARB_ROUND_ROBIN_EN selects round-robin
// with a rotating pointer; otherwise fixed priority (lowest index wins).
// Grants are only produced while 'advance' is high.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
`ifdef APB_ARB_ROUND_ROBIN_EN
  input  logic                       clk,
  input  logic                       rst,
`endif
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef APB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               k;

  // Search from the pointer upward (modulo NUM_REQ); first pending request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      cand = IDX_W'(k);
      if (!found && advance && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Pointer moves just past the last winner.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan downward so the lowest pending index is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (advance && req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/apb_request_arbiter.sv
// Multi-requester APB master: arbitrates requesters, decodes 4 KB slave
// regions to a one-hot PSEL, runs SETUP/ACCESS and returns a one-cycle
// response to the winner. Build option: APB_ARB_ROUND_ROBIN_EN.
module apb_request_arbiter
  import apb_arb_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [NUM_REQ*32-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0]       req_write,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    pslverr
);

  localparam int IDX_W        = $clog2(NUM_REQ);
  localparam int SIDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int REGION_SHIFT = $clog2(APB_REGION_BYTES);

  apb_state_e         state_q, state_d;
  logic [31:0]        paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               hit_q, hit_d;
  logic [SIDX_W-1:0]  sidx_q, sidx_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               advance;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [31:0]        win_addr, off, region;

  // Reset masks the grant so req_ready stays low while rst is high.
  assign advance = (state_q == ST_IDLE) && !rst;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef APB_ARB_ROUND_ROBIN_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: select only on a decode hit; enable marks the ACCESS phase.
  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    case (state_q)
      ST_SETUP:  if (hit_q) PSEL[sidx_q] = 1'b1;
      ST_ACCESS: begin
        if (hit_q) PSEL[sidx_q] = 1'b1;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // Winner payload mux and region decode; latched at the accept edge.
  always_comb begin
    win_addr = req_addr[32'(grant_idx) * 32 +: 32];
    off      = win_addr - BASE_ADDR;
    region   = off >> REGION_SHIFT;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    gidx_d   = gidx_q;
    hit_d    = hit_q;
    sidx_d   = sidx_q;
    if (|grant) begin
      paddr_d  = win_addr;
      pwdata_d = req_wdata[32'(grant_idx) * 32 +: 32];
      pwrite_d = req_write[grant_idx];
      gidx_d   = grant_idx;
      hit_d    = region < 32'(NUM_SLAVES);
      sidx_d   = region[SIDX_W-1:0];
    end
  end

  // Response capture at the end of ACCESS; data/err hold between responses.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == ST_ACCESS) begin
      rsp_valid_d[gidx_q] = 1'b1;
      if (!hit_q) begin
        rsp_rdata_d = APB_DECODE_ERR_DATA;
        rsp_err_d   = 1'b1;
      end else begin
        rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA[32'(sidx_q) * 32 +: 32];
        rsp_err_d   = pslverr[sidx_q];
      end
    end
  end

  // Datapath and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      gidx_q      <= '0;
      hit_q       <= 1'b0;
      sidx_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      gidx_q      <= gidx_d;
      hit_q       <= hit_d;
      sidx_q      <= sidx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
